// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single combinational full-adder cell shared by every bit step.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial signed adder/subtractor, one bit per clock, LSB first.
// Optional carry/no-borrow output enabled by SERIAL_ADDSUB_CARRY_OUT_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one full-adder step per cycle, WIDTH cycles
// DONE  | result held with out_valid until out_ready
module serial_adder_subtractor
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
    ,
    output logic             carry_out
`endif
);

    localparam int              CW       = clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    bit_cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    // Gated with rst so in_ready is low during the reset cycle itself.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt == CNT_LAST);

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept)    state_n = RUN;
            RUN:  if (last_bit)  state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default:             state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            bit_cnt   <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
            carry_out <= 1'b0;
`endif
        end else begin
            out_valid <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtract as a + ~b + 1: invert B and seed the carry.
                        a_sr    <= a;
                        b_sr    <= b ^ {WIDTH{opcode}};
                        carry   <= (opcode == OP_SUB);
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum     <= {fa_s, sum[WIDTH-1:1]};
                    carry   <= fa_cout;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last_bit) begin
                        // On the MSB step the carry register is the carry into the MSB.
                        overflow  <= carry ^ fa_cout;
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
                        carry_out <= fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Scoreboard bench for serial_adder_subtractor (WIDTH=8); carry_out checked when
// SERIAL_ADDSUB_CARRY_OUT_EN is defined.
module tb_serial_adder_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         overflow;
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
    logic         carry_out;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         ov;
        logic         co;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    serial_adder_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
        ,
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        int         sx;
        int         sy;
        int         r;
        logic [W:0] u;
        exp_t       e;
        sx   = $signed(x);
        sy   = $signed(y);
        r    = op ? (sx - sy) : (sx + sy);
        u    = {1'b0, x} + {1'b0, y};
        e.s  = r[W-1:0];
        e.ov = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
        e.co = op ? (x >= y) : u[W];
        return e;
    endfunction

    // Present one operand bundle, wait for acceptance, push its expected result.
    task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        bit done;
        done = 1'b0;
        @(negedge clk);
        a        = x;
        b        = y;
        opcode   = op;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                sb.push_back(model(x, y, op));
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        checks++; if (sum !== '0)         begin errors++; $display("FAIL rst_sum: got %h need 00", sum); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_overflow: got %b need 0", overflow); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4]  = '{8'd100, 8'd100, 8'h80, 8'd5};
        logic [W-1:0] tb_[4] = '{8'd27,  8'd28,  8'd1,  8'd7};
        logic         top[4] = '{1'b0,   1'b0,   1'b1,  1'b1};
        logic [W-1:0] ts[4]  = '{8'd127, 8'h80,  8'd127, 8'hFE};
        logic         tov[4] = '{1'b0,   1'b1,   1'b1,  1'b0};
        logic         tco[4] = '{1'b0,   1'b0,   1'b1,  1'b0};
        int           n;
        exp_t         e;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_op(ta[k], tb_[k], top[k]);
            wait_valid(n);
            checks++; if (n !== 9) begin errors++; $display("FAIL latency[%0d]: got %0d need 9", k, n); end
            e = sb.pop_front();
            checks++; if (sum !== ts[k])       begin errors++; $display("FAIL dir_sum[%0d]: got %h need %h", k, sum, ts[k]); end
            checks++; if (overflow !== tov[k]) begin errors++; $display("FAIL dir_ovf[%0d]: got %b need %b", k, overflow, tov[k]); end
            checks++; if (sum !== e.s)         begin errors++; $display("FAIL dir_model_sum[%0d]: got %h need %h", k, sum, e.s); end
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
            checks++; if (carry_out !== tco[k]) begin errors++; $display("FAIL dir_cout[%0d]: got %b need %b", k, carry_out, tco[k]); end
`else
            if (tco[k] !== e.co) $display("note: model carry disagrees with table at %0d", k);
`endif
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_ov_clear[%0d]: got %b need 0", k, out_valid); end
            checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL dir_idle[%0d]: got %b need 1", k, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int           n;
        logic [W-1:0] hs;
        logic         ho;
        exp_t         e;
        out_ready = 1'b0;
        drive_op(8'd50, 8'd236, 1'b0);
        wait_valid(n);
        checks++; if (n !== 9) begin errors++; $display("FAIL bp_latency: got %0d need 9", n); end
        hs       = sum;
        ho       = overflow;
        a        = 8'd1;
        b        = 8'd2;
        opcode   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (sum !== hs)         begin errors++; $display("FAIL bp_sum_hold: got %h need %h", sum, hs); end
            checks++; if (overflow !== ho)    begin errors++; $display("FAIL bp_ovf_hold: got %b need %b", overflow, ho); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b need 1", out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready: got %b need 0", in_ready); end
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (sum !== e.s || sum !== 8'd30) begin errors++; $display("FAIL bp_sum: got %h need %h", sum, e.s); end
        checks++; if (overflow !== e.ov)            begin errors++; $display("FAIL bp_ovf: got %b need %b", overflow, e.ov); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b need 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int   n;
        exp_t e;
        out_ready = 1'b1;
        drive_op(8'd20, 8'd30, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_during: got %b need 0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b need 0", out_valid); end
        checks++; if (sum !== '0)         begin errors++; $display("FAIL midrst_sum: got %h need 00", sum); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL midrst_ovf: got %b need 0", overflow); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready: got %b need 1", in_ready); end
        drive_op(8'hFF, 8'hFF, 1'b0);
        wait_valid(n);
        checks++; if (n !== 9) begin errors++; $display("FAIL midrst_latency: got %0d need 9", n); end
        e = sb.pop_front();
        checks++; if (sum !== 8'hFE || sum !== e.s) begin errors++; $display("FAIL midrst_sum2: got %h need fe", sum); end
        checks++; if (overflow !== 1'b0)            begin errors++; $display("FAIL midrst_ovf2: got %b need 0", overflow); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa[3] = '{8'd3,  8'hF0, 8'd127};
        logic [W-1:0] xb[3] = '{8'd4,  8'd16, 8'hFF};
        logic         xo[3] = '{1'b0,  1'b1,  1'b1};
        int           acc_cyc[3];
        int           k;
        int           rx;
        bit           acc;
        exp_t         e;
        k         = 0;
        rx        = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        a        = xa[0];
        b        = xb[0];
        opcode   = xo[0];
        in_valid = 1'b1;
        for (int g = 0; g < 200 && rx < 3; g++) begin
            @(negedge clk);
            acc = 1'b0;
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, opcode));
                acc_cyc[k] = cyc;
                k++;
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                rx++;
                checks++; if (sum !== e.s)      begin errors++; $display("FAIL b2b_sum[%0d]: got %h need %h", rx, sum, e.s); end
                checks++; if (overflow !== e.ov) begin errors++; $display("FAIL b2b_ovf[%0d]: got %b need %b", rx, overflow, e.ov); end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (k < 3) begin
                    a      = xa[k];
                    b      = xb[k];
                    opcode = xo[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (rx !== 3) begin errors++; $display("FAIL b2b_count: got %0d need 3", rx); end
        if (k == 3) begin
            checks++; if (acc_cyc[1] - acc_cyc[0] !== W + 2) begin errors++; $display("FAIL b2b_ii0: got %0d need %0d", acc_cyc[1] - acc_cyc[0], W + 2); end
            checks++; if (acc_cyc[2] - acc_cyc[1] !== W + 2) begin errors++; $display("FAIL b2b_ii1: got %0d need %0d", acc_cyc[2] - acc_cyc[1], W + 2); end
        end
    endtask

    task automatic test_random();
        localparam int N = 1000;
        int           sent;
        int           rx;
        bit           acc;
        bit           held;
        logic [W-1:0] hs;
        logic         ho;
        exp_t         e;
        sent      = 0;
        rx        = 0;
        held      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int g = 0; g < 40000 && rx < N; g++) begin
            @(negedge clk);
            acc = 1'b0;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== hs || overflow !== ho) begin
                    errors++;
                    $display("FAIL rnd_hold: got v=%b s=%h o=%b need v=1 s=%h o=%b", out_valid, sum, overflow, hs, ho);
                end
            end
            held = 1'b0;
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, opcode));
                sent++;
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                rx++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_extra: got result %h with empty queue, need none", sum);
                end else begin
                    e = sb.pop_front();
                    checks++; if (sum !== e.s)       begin errors++; $display("FAIL rnd_sum[%0d]: got %h need %h", rx, sum, e.s); end
                    checks++; if (overflow !== e.ov) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b need %b", rx, overflow, e.ov); end
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
                    checks++; if (carry_out !== e.co) begin errors++; $display("FAIL rnd_cout[%0d]: got %b need %b", rx, carry_out, e.co); end
`endif
                end
            end else if (out_valid) begin
                held = 1'b1;
                hs   = sum;
                ho   = overflow;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            if (!in_valid && sent < N && ($urandom_range(3) != 0)) begin
                a        = W'($urandom);
                b        = W'($urandom);
                opcode   = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (rx !== N)       begin errors++; $display("FAIL rnd_count: got %0d need %0d", rx, N); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d queued need 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
